led_chaser_gen2: RTL and testbench
==================================

Name: led_chaser_gen2

Overview:
Parametrised LED chaser: a lit (or dark) cursor advances across N_LED LEDs at a programmable rate and step, accumulating a trail until a full lap completes, then restarts the trail.
Successor to the fixed 16-LED/1-or-2-step controller. Adds arbitrary LED count, step 1..3, up/down direction, run/pause, synchronous restart, and correct lap detection for any start/step.
Runs on the 100 MHz system clock with an internal tick prescaler, so no derived clock is used. Position output feeds the existing 7-segment scanner.

Parameters:
N_LED, 16, number of LEDs (2..64); POS_W = $clog2(N_LED) is a derived localparam
CLK_HZ, 100_000_000, input clock frequency
BASE_HZ, 1, step rate at speed=0

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
run  in  1  1 = advance on ticks; 0 = pause (pattern and prescaler held)
load  in  1  single-cycle synchronous restart pulse
start_pos  in  POS_W  origin LED index
step  in  2  positions per tick (0 = hold, 1..3)
dir  in  1  0 = increasing index, 1 = decreasing
speed  in  2  rate = BASE_HZ << speed
light_mode  in  1  0 = light cursor on dark, 1 = dark cursor on lit
bounce  in  1  ping-pong mode (see Optional Feature)
led  out  N_LED  LED drive
position  out  POS_W  current cursor index
lap_done  out  1  one-cycle pulse at lap completion
tick  out  1  prescaler strobe (debug)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mask=0, led=0, position=0, lap_done=0, tick=0, prescaler=0, dist=0.
- Internal lit mask `mask`. Output `led` is registered as mask ^ {N_LED{light_mode}}, so it lags mask by 1 cycle. A light_mode change takes effect 1 cycle later with no restart.
- Prescaler: DIV = (CLK_HZ/BASE_HZ) >> speed, minimum 1. Counter runs 0..DIV-1 and asserts tick for 1 cycle at DIV-1. It is held while run=0 or state=IDLE, and cleared on load.
- start_pos ≥ N_LED is clamped to N_LED-1.
- State machine:
  - IDLE: entered after reset; no ticks are consumed. Leaves on load, or on run=1, going to START.
  - START (1 cycle): origin=pos=clamped start_pos, mask=one-hot(pos), dist=0. Goes to RUN.
  - RUN, on tick with step≠0:
    - pos_next = (pos ± step) mod N_LED, using an explicit compare/subtract (N_LED need not be a power of two).
    - mask[pos_next]=1; dist += step.
    - If dist ≥ N_LED: dist -= N_LED, mask=one-hot(pos_next), lap_done=1 for that cycle.
  - step=0: ticks are consumed with no motion.
- load in any state goes to START on the next edge.
- load and tick in the same cycle: load wins and the tick is dropped.
- position = pos register; it updates on the same edge as mask.
- dir or step change mid-lap: applied at the next tick; dist continues accumulating. Lap = N_LED cumulative steps regardless of direction.
- rst_n deasserting mid-operation: state returns to reset values immediately.

Optional Feature:
Macro LED_CHASER_BOUNCE_EN.
- Defined, with bounce=1: no wrap. An overshoot past an end reflects (pos_next = 2·end − raw) and the internal direction flips. lap_done pulses when the cursor reflects at index 0. The mask is cleared to one-hot at that reflection instead of by dist. dir is resampled on START.
- Not defined: the bounce input is ignored, the reflection logic is absent, and behaviour is wrap-only as above.

Decomposition:
- Package led_chaser_pkg: state enum (IDLE, START, RUN), the step-width constant, and a clamp function for start_pos.
- One sub-module, tick_prescaler (CLK_HZ, BASE_HZ; inputs en, clr, speed; output tick), reusable by the 7-segment refresh path.
- Wrap/reflect arithmetic stays inline.

Test Plan:
All scenarios use CLK_HZ=16, BASE_HZ=1, N_LED=16.
1. Reset, then run=1, start_pos=3, step=1, dir=0, speed=0 -> led=0x0008 after START+1; one tick every 16 cycles; after 15 ticks led=0xFFFF; 16th tick gives lap_done pulse, led=0x0008, position=3.
2. Test 2 uses N_LED=10, start_pos=9, step=2 -> positions 9,1,3,5,7,9; lap_done on the 5th tick. No stall (this is the odd/even origin case).
3. Same stimulus as test 1 with light_mode=1 -> led=0xFFF7 initially; toggling light_mode mid-lap inverts led 1 cycle later with position unchanged.
4. speed=2 -> tick period 4 cycles. Then run=0 for 20 cycles -> led/position frozen and the prescaler count preserved; resumes on run=1.
5. Pulse load coincident with tick mid-lap; also assert rst_n=0 mid-lap -> load: START with no advance. Reset: led=0 and position=0 asynchronously, before the next edge.
6. With LED_CHASER_BOUNCE_EN, bounce=1, start_pos=13, step=3 -> positions 13,14(reflect),11,…,2,1(reflect, lap_done); without the macro the same stimulus wraps to 0.

Source files
------------

// File: rtl/led_chaser_gen2_pkg.sv
// Shared types and helpers for the LED chaser and its tick prescaler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_chaser_pkg;

  // Chaser control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Width of the step input (0 = hold, 1..3 positions per tick)
  localparam int STEP_W  = 2;
  // Width of the speed input (rate = BASE_HZ << speed)
  localparam int SPEED_W = 2;

  // Out-of-range origins snap to the last LED
  function automatic int unsigned clamp_start(input int unsigned p, input int unsigned n);
    return (p >= n) ? (n - 1) : p;
  endfunction

endpackage

// File: rtl/led_chaser_gen2_tick_prescaler.sv
// Tick prescaler: one-cycle strobe every (CLK_HZ/BASE_HZ)>>speed enabled cycles (minimum 1).
// Latency: tick is combinational from the count register; clr zeroes the count on the next edge.
// Backpressure: en=0 freezes the count; clr suppresses the strobe in its cycle.
module tick_prescaler
  import led_chaser_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned BASE_HZ = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  localparam int unsigned BASE_DIV = ((CLK_HZ / BASE_HZ) > 0) ? (CLK_HZ / BASE_HZ) : 1;
  localparam int          CNT_W    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  logic [31:0]      div_full;
  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal count for the current speed; never lets the divider reach zero
  always_comb begin
    div_full = BASE_DIV >> speed;
    if (div_full == 32'd0) begin
      div_full = 32'd1;
    end
    div_m1 = CNT_W'(div_full - 32'd1);
  end

  // >= rather than == so a speed increase mid-count wraps immediately
  assign tick = en && !clr && (cnt_q >= div_m1);

  // Count 0..DIV-1 while enabled, hold otherwise, restart on clr
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q >= div_m1) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser_gen2.sv
// LED chaser: cursor advances by step on each prescaler tick, trail accumulates until a lap completes.
// Latency: position/lap_done update on the tick edge; led follows one cycle later. Optional ping-pong via LED_CHASER_BOUNCE_EN.
// Backpressure: run=0 freezes pattern and prescaler; load restarts from START and drops a coincident tick.
module led_chaser_gen2
  import led_chaser_pkg::*;
#(
  parameter  int unsigned N_LED   = 16,
  parameter  int unsigned CLK_HZ  = 100_000_000,
  parameter  int unsigned BASE_HZ = 1,
  localparam int          POS_W   = $clog2(N_LED)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               load,
  input  logic [POS_W-1:0]   start_pos,
  input  logic [STEP_W-1:0]  step,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic               light_mode,
  input  logic               bounce,
  output logic [N_LED-1:0]   led,
  output logic [POS_W-1:0]   position,
  output logic               lap_done,
  output logic               tick
);

  // Arithmetic width holds pos + 2*N_LED; distance width holds dist + max step
  localparam int               AW       = POS_W + 3;
  localparam int               DW       = POS_W + 2;
  localparam logic [AW-1:0]    N_A      = AW'(N_LED);
  localparam logic [DW-1:0]    N_D      = DW'(N_LED);
  localparam logic [N_LED-1:0] ONE_HOT0 = N_LED'(1);

  state_e           state_q, state_d;
  logic [N_LED-1:0] mask_q, mask_d;
  logic [N_LED-1:0] led_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DW-1:0]    dist_q, dist_d;
  logic             lap_q, lap_d;

  logic             presc_en, tick_w, do_start, do_step;
  logic [POS_W-1:0] start_clamped;

  // Wrap-mode step result
  logic [AW-1:0]    w_raw;
  logic [POS_W-1:0] w_pos;
  logic [N_LED-1:0] w_mask;
  logic [DW-1:0]    w_dist;
  logic             w_lap;

  assign start_clamped = POS_W'(clamp_start(32'(start_pos), N_LED));

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .BASE_HZ (BASE_HZ)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (load),
    .speed (speed),
    .tick  (tick_w)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: load from anywhere restarts; run kicks IDLE into START
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = START;
    end else begin
      case (state_q)
        IDLE:    state_d = run ? START : IDLE;
        START:   state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: prescaler enable and datapath strobes
  always_comb begin
    presc_en = run && (state_q != IDLE);
    do_start = (state_q == START);
    do_step  = (state_q == RUN) && tick_w && !load && (step != '0);
  end

  // Modulo step via bounded compare/subtract; 2*N_LED bias keeps the down case non-negative even for N_LED < step
  always_comb begin
    w_raw = dir ? (AW'(pos_q) + N_A + N_A - AW'(step)) : (AW'(pos_q) + AW'(step));
    if (w_raw >= N_A) w_raw = w_raw - N_A;
    if (w_raw >= N_A) w_raw = w_raw - N_A;
    w_pos  = POS_W'(w_raw);
    w_mask = mask_q | (ONE_HOT0 << w_pos);
    w_dist = dist_q + DW'(step);
    w_lap  = 1'b0;
    if (w_dist >= N_D) begin
      w_lap  = 1'b1;
      w_mask = ONE_HOT0 << w_pos;
      w_dist = w_dist - N_D;
      // Second subtract only matters for tiny N_LED where step can exceed the lap length
      if (w_dist >= N_D) w_dist = w_dist - N_D;
    end
  end

`ifdef LED_CHASER_BOUNCE_EN
  localparam logic signed [AW:0] LAST_S     = (AW+1)'(N_LED - 1);
  localparam logic signed [AW:0] TWO_LAST_S = (AW+1)'(2 * (N_LED - 1));

  logic                dir_q, dir_d;
  logic signed [AW:0]  b_raw, b_ref;
  logic [POS_W-1:0]    b_pos;
  logic                b_flip, b_lap;

  // Reflect overshoot off either end; the low-end reflection closes a lap
  always_comb begin
    b_flip = 1'b0;
    b_lap  = 1'b0;
    b_raw  = dir_q ? ($signed((AW+1)'(pos_q)) - $signed((AW+1)'(step)))
                   : ($signed((AW+1)'(pos_q)) + $signed((AW+1)'(step)));
    b_ref  = b_raw;
    if (!dir_q && (b_raw > LAST_S)) begin
      b_ref  = TWO_LAST_S - b_raw;
      b_flip = 1'b1;
    end else if (dir_q && b_raw[AW]) begin
      b_ref  = -b_raw;
      b_flip = 1'b1;
      b_lap  = 1'b1;
    end
    // Large steps on very short strips could still land outside; pin to the ends
    if (b_ref[AW]) begin
      b_ref = '0;
    end else if (b_ref > LAST_S) begin
      b_ref = LAST_S;
    end
    b_pos = POS_W'(b_ref);
  end

  // Ping-pong direction, sampled from dir at START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  logic unused_bounce;
  assign unused_bounce = bounce;
`endif

  // Datapath next state: START seeds the origin, a tick moves the cursor
  always_comb begin
    pos_d  = pos_q;
    mask_d = mask_q;
    dist_d = dist_q;
    lap_d  = 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
    dir_d  = dir_q;
`endif
    if (do_start) begin
      pos_d  = start_clamped;
      mask_d = ONE_HOT0 << start_clamped;
      dist_d = '0;
`ifdef LED_CHASER_BOUNCE_EN
      dir_d  = dir;
`endif
    end else if (do_step) begin
`ifdef LED_CHASER_BOUNCE_EN
      if (bounce) begin
        pos_d  = b_pos;
        lap_d  = b_lap;
        mask_d = b_lap ? (ONE_HOT0 << b_pos) : (mask_q | (ONE_HOT0 << b_pos));
        if (b_flip) dir_d = ~dir_q;
      end else begin
        pos_d  = w_pos;
        mask_d = w_mask;
        dist_d = w_dist;
        lap_d  = w_lap;
      end
`else
      pos_d  = w_pos;
      mask_d = w_mask;
      dist_d = w_dist;
      lap_d  = w_lap;
`endif
    end
  end

  // Pattern registers; led is the polarity-adjusted mask one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      mask_q <= '0;
      dist_q <= '0;
      lap_q  <= 1'b0;
      led_q  <= '0;
    end else begin
      pos_q  <= pos_d;
      mask_q <= mask_d;
      dist_q <= dist_d;
      lap_q  <= lap_d;
      led_q  <= mask_q ^ {N_LED{light_mode}};
    end
  end

  assign led      = led_q;
  assign position = pos_q;
  assign lap_done = lap_q;
  assign tick     = tick_w;

endmodule

// File: tb/tb_led_chaser_gen2.sv
// Directed bench for led_chaser_gen2 (16-LED and 10-LED instances, CLK_HZ=16).
// Expected tick results are queued when stimulus is set and popped as ticks appear.
// Honours LED_CHASER_BOUNCE_EN for the ping-pong scenario.
module tb_led_chaser_gen2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, load, dir, light_mode, bounce;
  logic [3:0]  start_pos;
  logic [1:0]  step, speed;

  logic [15:0] led16;
  logic [3:0]  pos16;
  logic        lap16, tick16;
  logic [9:0]  led10;
  logic [3:0]  pos10;
  logic        lap10, tick10;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          pos;
    logic        lap;
    logic [15:0] mask;
    int          gap;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_chaser_gen2 #(.N_LED(16), .CLK_HZ(16), .BASE_HZ(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load), .start_pos(start_pos),
    .step(step), .dir(dir), .speed(speed), .light_mode(light_mode), .bounce(bounce),
    .led(led16), .position(pos16), .lap_done(lap16), .tick(tick16)
  );

  led_chaser_gen2 #(.N_LED(10), .CLK_HZ(16), .BASE_HZ(1)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load), .start_pos(start_pos),
    .step(step), .dir(dir), .speed(speed), .light_mode(light_mode), .bounce(bounce),
    .led(led10), .position(pos10), .lap_done(lap10), .tick(tick10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Queue a wrap-mode lap model from a fresh START
  task automatic push_wrap(input int n_led, input int p0, input int stp, input bit dn,
                           input int nt, input int g);
    int p, d;
    logic [15:0] m;
    exp_t e;
    p = p0; d = 0; m = 16'(1) << p0;
    for (int k = 0; k < nt; k++) begin
      p = dn ? (p + 2 * n_led - stp) % n_led : (p + stp) % n_led;
      m = m | (16'(1) << p);
      d = d + stp;
      e.lap = 1'b0;
      if (d >= n_led) begin
        d = d - n_led;
        m = 16'(1) << p;
        e.lap = 1'b1;
      end
      e.pos = p; e.mask = m; e.gap = (k == 0) ? -1 : g;
      sb.push_back(e);
    end
  endtask

  task automatic push_one(input int p, input logic lp, input logic [15:0] m, input int g);
    exp_t e;
    e.pos = p; e.lap = lp; e.mask = m; e.gap = g;
    sb.push_back(e);
  endtask

  // Wait for the next tick, then compare position/lap and, a cycle later, led
  task automatic step_check(input bit sel, input string tag);
    int n;
    exp_t e;
    logic [15:0] exp_led;
    n = 0;
    while (((sel ? tick10 : tick16) !== 1'b1) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      fail_now({tag, "_tick"});
      return;
    end
    if (sb.size() == 0) begin
      fail_now({tag, "_sb_empty"});
      return;
    end
    e = sb.pop_front();
    if (e.gap >= 0) chk({tag, "_gap"}, n, e.gap);
    @(negedge clk);
    chk({tag, "_pos"}, sel ? pos10 : pos16, e.pos);
    chk({tag, "_lap"}, sel ? lap10 : lap16, e.lap);
    @(negedge clk);
    exp_led = e.mask ^ {16{light_mode}};
    if (sel) chk({tag, "_led"}, led10, exp_led & 16'h03FF);
    else     chk({tag, "_led"}, led16, exp_led);
  endtask

  initial begin
    int ntick;
    rst_n = 1'b0; run = 1'b0; load = 1'b0; start_pos = 4'd0; step = 2'd0;
    dir = 1'b0; speed = 2'd0; light_mode = 1'b0; bounce = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_led", led16, 16'h0000);
    chk("rst_pos", pos16, 0);
    chk("rst_lap", lap16, 0);
    chk("rst_tick", tick16, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_led", led16, 16'h0000);
    chk("idle_tick", tick16, 0);

    // 1: full lap from origin 3, step 1
    start_pos = 4'd3; step = 2'd1; dir = 1'b0; speed = 2'd0; run = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_start_pos", pos16, 3);
    @(negedge clk);
    chk("t1_start_led", led16, 16'h0008);
    push_wrap(16, 3, 1, 1'b0, 16, 14);
    for (int k = 0; k < 16; k++) step_check(1'b0, $sformatf("t1_k%0d", k));

    // 3: inverted polarity, then mid-lap toggle
    light_mode = 1'b1; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); chk("t3_start_pos", pos16, 3);
    @(negedge clk); chk("t3_start_led", led16, 16'hFFF7);
    push_wrap(16, 3, 1, 1'b0, 4, 14);
    for (int k = 0; k < 4; k++) step_check(1'b0, $sformatf("t3_k%0d", k));
    light_mode = 1'b0;
    #1 chk("t3_toggle_hold", led16, 16'hFF07);
    @(negedge clk);
    chk("t3_toggle_led", led16, 16'h00F8);
    chk("t3_toggle_pos", pos16, 7);

    // 2: N_LED=10, odd origin, step 2
    start_pos = 4'd9; step = 2'd2; speed = 2'd2; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); chk("t2_start_pos", pos10, 9);
    @(negedge clk); chk("t2_start_led", led10, 10'h200);
    push_wrap(10, 9, 2, 1'b0, 5, 2);
    for (int k = 0; k < 5; k++) step_check(1'b1, $sformatf("t2_k%0d", k));

    // Clamp of out-of-range origin, and step=0 consuming ticks without motion
    start_pos = 4'd15; step = 2'd0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    chk("clamp_pos10", pos10, 9);
    chk("clamp_pos16", pos16, 15);
    @(negedge clk); chk("clamp_led10", led10, 10'h200);
    push_one(9, 1'b0, 16'h0200, -1);
    step_check(1'b1, "step0");

    // 4: speed 2, downward, then pause 20 cycles
    start_pos = 4'd0; step = 2'd1; dir = 1'b1; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); chk("t4_start_pos", pos16, 0);
    @(negedge clk); chk("t4_start_led", led16, 16'h0001);
    push_wrap(16, 0, 1, 1'b1, 3, 2);
    for (int k = 0; k < 3; k++) step_check(1'b0, $sformatf("t4_k%0d", k));
    run = 1'b0; ntick = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick16 === 1'b1) ntick++;
    end
    chk("t4_pause_ticks", ntick, 0);
    chk("t4_pause_pos", pos16, 13);
    chk("t4_pause_led", led16, 16'hE001);
    run = 1'b1;
    push_one(12, 1'b0, 16'hF001, 2);
    step_check(1'b0, "t4_resume");

    // 5: load coincident with tick, then async reset mid-lap
    start_pos = 4'd5; dir = 1'b0; ntick = 0;
    while (tick16 !== 1'b1 && ntick < 16) begin
      @(negedge clk);
      ntick++;
    end
    if (ntick >= 16) fail_now("t5_tick");
    load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("t5_load_noadv_pos", pos16, 12);
    chk("t5_load_lap", lap16, 0);
    @(negedge clk);
    chk("t5_start_pos", pos16, 5);
    chk("t5_load_noadv_led", led16, 16'hF001);
    @(negedge clk); chk("t5_start_led", led16, 16'h0020);
    push_wrap(16, 5, 1, 1'b0, 1, 2);
    step_check(1'b0, "t5_tick");
    rst_n = 1'b0;
    #1;
    chk("t5_arst_led", led16, 16'h0000);
    chk("t5_arst_pos", pos16, 0);
    chk("t5_arst_tick", tick16, 0);

    // 6: ping-pong (or plain wrap when the feature is compiled out)
    start_pos = 4'd13; step = 2'd3; dir = 1'b0; speed = 2'd2; bounce = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_start_pos", pos16, 13);
    @(negedge clk); chk("t6_start_led", led16, 16'h2000);
`ifdef LED_CHASER_BOUNCE_EN
    push_one(14, 1'b0, 16'h6000, -1);
    push_one(11, 1'b0, 16'h6800, 2);
    push_one(8,  1'b0, 16'h6900, 2);
    push_one(5,  1'b0, 16'h6920, 2);
    push_one(2,  1'b0, 16'h6924, 2);
    push_one(1,  1'b1, 16'h0002, 2);
`else
    push_wrap(16, 13, 3, 1'b0, 6, 2);
`endif
    for (int k = 0; k < 6; k++) step_check(1'b0, $sformatf("t6_k%0d", k));

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
